updown_mod_counter: RTL and testbench
=====================================

# updown_mod_counter

Parametrised synchronous up/down counter with programmable modulus, wrap or saturate mode, parallel load, synchronous clear and terminal-count/overflow flags. Next generation of the team's fixed 2-bit counter, used as the general-purpose counting primitive for timers, address generators and lab-board display dividers. Single clock domain, asynchronous active-high reset.

## Interface
- WIDTH, 8, counter width in bits (1..32).
- MODULUS, 2**WIDTH, count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH.
- SATURATE, 0, 0 = wrap at range ends, 1 = hold at range ends.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- clr  in  1  synchronous clear to 0, highest synchronous priority.
- load  in  1  synchronous parallel load of load_val.
- load_val  in  WIDTH  value to load; clamped to MODULUS-1 if larger.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- count  out  WIDTH  registered counter value.
- tc  out  1  combinational terminal count: en & ((up & count==MODULUS-1) | (~up & count==0)).
- wrap  out  1  registered one-cycle pulse, high the cycle after a wrap or saturation-blocked step.
- ovf  out  1  registered sticky flag, set with wrap, cleared only by clr or reset.

## Operation
- Synchronous priority per edge: clr > load > en > hold.
- clr: count<=0, ovf<=0, wrap<=0.
- load (clr low): count<=min(load_val, MODULUS-1); wrap<=0; ovf unchanged; en/up ignored this cycle.
- en, up=1: count<MODULUS-1 -> count+1; count==MODULUS-1 -> 0 (SATURATE=0) or hold (SATURATE=1); in both cases wrap<=1, ovf<=1.
- en, up=0: count>0 -> count-1; count==0 -> MODULUS-1 (SATURATE=0) or hold (SATURATE=1); wrap<=1, ovf<=1.
- en low, no clr/load: count and ovf hold, wrap<=0.
- Arithmetic done in WIDTH bits; comparison against MODULUS-1 constant, never relies on natural 2**WIDTH rollover, so non-power-of-two MODULUS wraps correctly.
- Direction change mid-count takes effect on the same edge; no dead cycle.
- If count ever holds a value >= MODULUS (not reachable through the ports), the next enabled step treats it as terminal.

## Timing
- Reset values: count=0, wrap=0, ovf=0; tc=0 while reset held (en qualifies but count==0 with up=0 and en=1 gives tc=1 after reset release: tc is purely combinational from count/en/up).
- Asynchronous assert, synchronous-safe deassert expected from the reset source; first count step on the first rising edge with reset low.
- count latency: 1 cycle from en/load/clr sample to new value.
- tc: 0-cycle combinational, valid in the same cycle as the step that will wrap; wrap follows 1 cycle later.
- Reset mid-count or during load: all outputs to reset values immediately; the pending operation is discarded.
- clr and load same cycle: clr wins, load_val ignored.

## Structure
- Shared package counter_pkg: direction constants (DIR_UP=1, DIR_DOWN=0), mode constants (MODE_WRAP=0, MODE_SAT=1), and a function computing the clamped load value.
- Next-value logic is one always block; no sub-module needed. Elaboration-time check rejects MODULUS outside 2..2**WIDTH.

## Test plan
- WIDTH=4, MODULUS=10, wrap: reset, en=1 up=1 for 12 cycles -> count 0..9,0,1; tc high at count 9; wrap high exactly one cycle after 9->0; ovf stays 1.
- Same config, up=0 from 0 -> count 9,8,7; wrap pulses after 0->9; tc high while count 0.
- SATURATE=1, MODULUS=16: load 14, count up 4 cycles -> 15,15,15,15 then hold; wrap pulses each blocked cycle; ovf=1; then clr -> count 0, ovf 0.
- Load clamp: MODULUS=10, load_val=13 -> count 9 next cycle; load and clr together -> count 0.
- Reset mid-operation: count at 7 counting up, assert reset asynchronously between edges -> count, wrap, ovf 0 before next edge; counting resumes 1 on first edge after release.
- Direction flip: count at 5, up toggles 1->0 each cycle with en=1 -> 6,5,6,5; no wrap, ovf unchanged.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulus counter family.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Limit a requested load value to the top of the counting range.
  function automatic logic [63:0] clamp_load(input logic [63:0] val,
                                             input logic [63:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/updown_mod_counter.sv
// Up/down counter with programmable modulus, wrap or saturate at the range ends,
// parallel load, synchronous clear, terminal-count and wrap/overflow flags.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
  parameter logic            SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [63:0]      MaxVal64 = MODULUS - 64'd1;
  localparam logic [WIDTH-1:0] MaxVal   = WIDTH'(MaxVal64);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("updown_mod_counter: WIDTH must be 1..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("updown_mod_counter: MODULUS must be 2..2**WIDTH");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             at_top, at_bottom;

  // Out-of-range values count as terminal in either direction.
  assign at_top    = (count_q >= MaxVal);
  assign at_bottom = (count_q == '0) || (count_q > MaxVal);

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = WIDTH'(clamp_load(64'(load_val), MaxVal64));
    end else if (en) begin
      if (up == DIR_UP) begin
        if (at_top) begin
          wrap_d = 1'b1;
          ovf_d  = 1'b1;
          if (SATURATE == MODE_WRAP) count_d = '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (at_bottom) begin
          wrap_d = 1'b1;
          ovf_d  = 1'b1;
          if (SATURATE == MODE_WRAP) count_d = MaxVal;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tc    = en & ((up & (count_q == MaxVal)) | (~up & (count_q == '0)));
  assign count = count_q;
  assign wrap  = wrap_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench: a wrapping mod-10 counter and a saturating mod-16 counter.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_clr, a_load, a_en, a_up;
  logic [3:0] a_load_val, a_count;
  logic       a_tc, a_wrap, a_ovf;
  logic       b_clr, b_load, b_en, b_up;
  logic [3:0] b_load_val, b_count;
  logic       b_tc, b_wrap, b_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .clr(a_clr), .load(a_load), .load_val(a_load_val),
    .en(a_en), .up(a_up), .count(a_count), .tc(a_tc), .wrap(a_wrap), .ovf(a_ovf)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .clr(b_clr), .load(b_load), .load_val(b_load_val),
    .en(b_en), .up(b_up), .count(b_count), .tc(b_tc), .wrap(b_wrap), .ovf(b_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string name, input logic [3:0] cnt, input logic wr,
                       input logic ov);
    total++;
    if (a_count !== cnt || a_wrap !== wr || a_ovf !== ov) begin
      bad++;
      $display("FAIL %s: count/wrap/ovf got %0d/%b/%b want %0d/%b/%b",
               name, a_count, a_wrap, a_ovf, cnt, wr, ov);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_clr = 0; a_load = 0; a_en = 0; a_up = 1; a_load_val = 0;
    b_clr = 0; b_load = 0; b_en = 0; b_up = 1; b_load_val = 0;
    step();
    step();
    chk_a("reset_a", 4'd0, 1'b0, 1'b0);
    total++;
    if (a_tc !== 1'b0) begin bad++; $display("FAIL reset_tc: got %b want 0", a_tc); end
    total++;
    if (b_count !== 4'd0 || b_wrap !== 1'b0 || b_ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_b: got %0d/%b/%b want 0/0/0", b_count, b_wrap, b_ovf);
    end
    reset = 1'b0;
    a_en = 1'b1; a_up = 1'b0;
    #1;
    total++;
    if (a_tc !== 1'b1) begin bad++; $display("FAIL tc_down_at_0: got %b want 1", a_tc); end
    a_en = 1'b0; a_up = 1'b1;
    #1;
  endtask

  task automatic test_count_up();
    a_en = 1'b1; a_up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      total++;
      if (a_tc !== ((i % 10) == 9)) begin
        bad++;
        $display("FAIL up_tc[%0d]: got %b want %b", i, a_tc, ((i % 10) == 9));
      end
      step();
      chk_a($sformatf("up[%0d]", i), 4'((i + 1) % 10), (i == 9), (i >= 9));
    end
    a_en = 1'b0;
  endtask

  task automatic test_count_down();
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    chk_a("clr_before_down", 4'd0, 1'b0, 1'b0);
    a_en = 1'b1; a_up = 1'b0;
    #1;
    total++;
    if (a_tc !== 1'b1) begin bad++; $display("FAIL down_tc: got %b want 1", a_tc); end
    step();
    chk_a("down_0", 4'd9, 1'b1, 1'b1);
    step();
    chk_a("down_1", 4'd8, 1'b0, 1'b1);
    step();
    chk_a("down_2", 4'd7, 1'b0, 1'b1);
    a_en = 1'b0;
    step();
    chk_a("hold", 4'd7, 1'b0, 1'b1);
  endtask

  task automatic test_load_clamp();
    a_load = 1'b1; a_load_val = 4'd13; a_en = 1'b1; a_up = 1'b1;
    step();
    chk_a("load_clamp", 4'd9, 1'b0, 1'b1);
    a_clr = 1'b1; a_load_val = 4'd5;
    step();
    chk_a("clr_beats_load", 4'd0, 1'b0, 1'b0);
    a_clr = 1'b0; a_load = 1'b0; a_en = 1'b0;
  endtask

  task automatic test_saturate();
    b_load = 1'b1; b_load_val = 4'd14;
    step();
    b_load = 1'b0;
    b_en = 1'b1; b_up = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (b_count !== 4'd15 || b_wrap !== (i > 0) || b_ovf !== (i > 0)) begin
        bad++;
        $display("FAIL sat_up[%0d]: got %0d/%b/%b want 15/%b/%b",
                 i, b_count, b_wrap, b_ovf, (i > 0), (i > 0));
      end
    end
    b_en = 1'b0;
    step();
    total++;
    if (b_count !== 4'd15 || b_wrap !== 1'b0 || b_ovf !== 1'b1) begin
      bad++;
      $display("FAIL sat_idle: got %0d/%b/%b want 15/0/1", b_count, b_wrap, b_ovf);
    end
    b_clr = 1'b1;
    step();
    b_clr = 1'b0;
    total++;
    if (b_count !== 4'd0 || b_ovf !== 1'b0) begin
      bad++;
      $display("FAIL sat_clr: got %0d/%b want 0/0", b_count, b_ovf);
    end
    b_en = 1'b1; b_up = 1'b0;
    step();
    b_en = 1'b0;
    total++;
    if (b_count !== 4'd0 || b_wrap !== 1'b1 || b_ovf !== 1'b1) begin
      bad++;
      $display("FAIL sat_down_0: got %0d/%b/%b want 0/1/1", b_count, b_wrap, b_ovf);
    end
  endtask

  task automatic test_reset_mid();
    a_load = 1'b1; a_load_val = 4'd8;
    step();
    a_load = 1'b0; a_en = 1'b1; a_up = 1'b1;
    step();
    step();
    chk_a("pre_reset_wrap", 4'd0, 1'b1, 1'b1);
    a_en = 1'b0; a_load = 1'b1; a_load_val = 4'd6;
    step();
    a_load = 1'b0; a_en = 1'b1;
    step();
    chk_a("pre_reset_7", 4'd7, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_a("async_reset", 4'd0, 1'b0, 1'b0);
    step();
    chk_a("reset_held", 4'd0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    chk_a("resume", 4'd1, 1'b0, 1'b0);
    a_en = 1'b0;
  endtask

  task automatic test_direction_flip();
    a_load = 1'b1; a_load_val = 4'd5;
    step();
    a_load = 1'b0;
    chk_a("flip_load", 4'd5, 1'b0, 1'b0);
    a_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_up = ((i % 2) == 0);
      step();
      chk_a($sformatf("flip[%0d]", i), ((i % 2) == 0) ? 4'd6 : 4'd5, 1'b0, 1'b0);
    end
    a_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load_clamp();
    test_saturate();
    test_reset_mid();
    test_direction_flip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
